display_mode_ctrl: RTL and testbench

//  Front-panel controller for the pixel colour-out stage.
//  - Debounces three active-low push buttons.
//  - Mode button cycles display mode COLOR -> GRAY -> BINARY -> COLOR.
//  - Up/down buttons trim the BINARY threshold.
//  - All changes are held pending and committed only at frame_start, so the

---
 rtl/display_ctrl_pkg.sv | 29 ++
 rtl/key_debounce.sv | 39 +++
 rtl/display_mode_ctrl.sv | 80 ++++++++
 tb/tb_display_mode_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/display_ctrl_pkg.sv
// display_ctrl_pkg: shared types, defaults and threshold arithmetic for the display mode controller
package display_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_COLOR  = 2'd0,
      MODE_GRAY   = 2'd1,
      MODE_BINARY = 2'd2
   } disp_mode_t;

   typedef enum logic {
      IDLE,
      PENDING
   } ctrl_state_t;

   localparam int         DEBOUNCE_CYCLES_C = 500000;
   localparam int         NUM_MODES_C       = 3;
   localparam logic [7:0] THRESH_DEFAULT_C  = 8'h80;
   localparam logic [7:0] THRESH_STEP_C     = 8'h08;

   // Saturating step; both directions at once cancel. The ninth bit flags overflow/underflow.
   function automatic logic [7:0] thresh_adj(input logic [7:0] t, input logic [7:0] step,
                                             input logic up, input logic dn);
      logic [8:0] s;
      s = (up & ~dn) ? {1'b0, t} + {1'b0, step} :
          (dn & ~up) ? {1'b0, t} - {1'b0, step} : {1'b0, t};
      return s[8] ? (up ? 8'hff : 8'h00) : s[7:0];
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises an active-low raw key, debounces it and emits a one-cycle press pulse
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;
   logic          settle;

   // The sample has disagreed with the accepted level for the full debounce window
   assign settle = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

   // Synchroniser, disagreement counter, accepted level and press pulse on the 1->0 acceptance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         cnt   <= (sync2 == level || settle) ? '0 : cnt + CW'(1);
         level <= settle ? sync2 : level;
         press <= settle & ~sync2;
      end
   end

endmodule

// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: front-panel mode/threshold control with changes committed only at frame_start
module display_mode_ctrl
   import display_ctrl_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_C,
   parameter int         NUM_MODES       = NUM_MODES_C,
   parameter logic [7:0] THRESH_DEFAULT  = THRESH_DEFAULT_C,
   parameter logic [7:0] THRESH_STEP     = THRESH_STEP_C
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       key_mode_n,
   input  logic       key_up_n,
   input  logic       key_dn_n,
   input  logic       frame_start,
   output disp_mode_t mode,
   output logic [7:0] threshold,
   output logic       pending,
   output logic       mode_update
);

   localparam disp_mode_t LAST_MODE = disp_mode_t'(2'(NUM_MODES - 1));

   logic        p_mode;
   logic        p_up;
   logic        p_dn;
   logic        any_press;
   logic        commit;
   ctrl_state_t state;
   ctrl_state_t state_d;
   disp_mode_t  next_mode;
   disp_mode_t  next_mode_d;
   disp_mode_t  mode_d;
   logic [7:0]  next_thresh;
   logic [7:0]  next_thresh_d;
   logic [7:0]  threshold_d;
   logic        mode_update_d;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk(clk), .reset_n(reset_n), .key_n(key_mode_n), .press(p_mode));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
      .clk(clk), .reset_n(reset_n), .key_n(key_up_n), .press(p_up));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dn (
      .clk(clk), .reset_n(reset_n), .key_n(key_dn_n), .press(p_dn));

   assign any_press = p_mode | p_up | p_dn;
   assign commit    = (state == PENDING) && frame_start;
   assign pending   = (state == PENDING);

   // Next state: commit the pre-press values at frame_start; a press always (re)opens a pending change
   always_comb begin
      state_d       = any_press ? PENDING : (commit ? IDLE : state);
      mode_d        = commit ? next_mode : mode;
      threshold_d   = commit ? next_thresh : threshold;
      mode_update_d = commit;
      next_mode_d   = !p_mode ? next_mode :
                      (next_mode == LAST_MODE) ? MODE_COLOR : disp_mode_t'(next_mode + 2'd1);
      next_thresh_d = thresh_adj(next_thresh, THRESH_STEP, p_up, p_dn);
   end

   // FSM, pending and committed registers; reset discards any uncommitted change silently
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mode        <= MODE_COLOR;
         threshold   <= THRESH_DEFAULT;
         next_mode   <= MODE_COLOR;
         next_thresh <= THRESH_DEFAULT;
         mode_update <= 1'b0;
      end else begin
         state       <= state_d;
         mode        <= mode_d;
         threshold   <= threshold_d;
         next_mode   <= next_mode_d;
         next_thresh <= next_thresh_d;
         mode_update <= mode_update_d;
      end
   end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// tb_display_mode_ctrl: directed self-checking bench for display_mode_ctrl with a short debounce window
module tb_display_mode_ctrl;
   import display_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       key_mode_n = 1'b1;
   logic       key_up_n = 1'b1;
   logic       key_dn_n = 1'b1;
   logic       frame_start = 1'b0;
   disp_mode_t mode;
   logic [7:0] threshold;
   logic       pending;
   logic       mode_update;

   int vectors = 0;
   int miscompares = 0;

   display_mode_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .key_mode_n(key_mode_n), .key_up_n(key_up_n),
      .key_dn_n(key_dn_n), .frame_start(frame_start), .mode(mode), .threshold(threshold),
      .pending(pending), .mode_update(mode_update));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Hold the selected keys low long enough to debounce, then release and let the release settle
   task automatic tap(input logic m, input logic u, input logic d);
      key_mode_n = ~m;
      key_up_n   = ~u;
      key_dn_n   = ~d;
      repeat (10) @(negedge clk);
      key_mode_n = 1'b1;
      key_up_n   = 1'b1;
      key_dn_n   = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // Pulse frame_start and check the commit cycle, then that mode_update was only one cycle
   task automatic frame_chk(input string tag, input logic [1:0] em, input logic [7:0] et,
                            input logic ep, input logic eu);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk({tag, ".mode"}, mode, em);
      chk({tag, ".thr"}, threshold, et);
      chk({tag, ".pend"}, pending, ep);
      chk({tag, ".upd"}, mode_update, eu);
      @(negedge clk);
      chk({tag, ".upd_off"}, mode_update, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst.mode", mode, 0);
      chk("rst.thr", threshold, 8'h80);
      chk("rst.pend", pending, 0);
      chk("rst.upd", mode_update, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         key_mode_n = 1'b0;
         repeat (3) @(negedge clk);
         key_mode_n = 1'b1;
         repeat (3) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("bounce.pend", pending, 0);
      tap(1, 0, 0);
      chk("hold.pend", pending, 1);
      chk("hold.mode", mode, 0);
      frame_chk("commit1", 2'd1, 8'h80, 0, 1);
      frame_chk("idle_frame", 2'd1, 8'h80, 0, 0);
      tap(1, 0, 0);
      tap(1, 0, 0);
      chk("two.mode_held", mode, 1);
      frame_chk("wrap", 2'd0, 8'h80, 0, 1);

      for (int i = 0; i < 20; i++) tap(0, 1, 0);
      chk("up.thr_held", threshold, 8'h80);
      frame_chk("sat_hi", 2'd0, 8'hff, 0, 1);
      for (int i = 0; i < 40; i++) tap(0, 0, 1);
      frame_chk("sat_lo", 2'd0, 8'h00, 0, 1);
      tap(0, 1, 0);
      tap(0, 1, 0);
      frame_chk("up2", 2'd0, 8'h10, 0, 1);
      tap(0, 1, 1);
      chk("updn.pend", pending, 1);
      frame_chk("updn", 2'd0, 8'h10, 0, 1);

      tap(1, 0, 0);
      tap(1, 0, 0);
      key_mode_n = 1'b0;
      repeat (6) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("simul.mode", mode, 2);
      chk("simul.upd", mode_update, 1);
      chk("simul.pend", pending, 1);
      key_mode_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("simul.pend2", pending, 1);
      frame_chk("simul_next", 2'd0, 8'h10, 0, 1);

      tap(1, 0, 0);
      tap(1, 0, 0);
      chk("mid.pend", pending, 1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid.mode", mode, 0);
      chk("mid.thr", threshold, 8'h80);
      chk("mid.pend0", pending, 0);
      chk("mid.upd", mode_update, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      frame_chk("after_rst", 2'd0, 8'h80, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
